// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the ram_5x32 two-port arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: combinational choice plus the registered last-grant pointer.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  cpu_req_i,
    input  logic  host_req_i,
    input  logic  take_i,
    output logic  gnt_c,
    output port_e gnt_port_c,
    output logic  contend_c
);

    port_e r_last;

    always_comb begin
        contend_c  = cpu_req_i & host_req_i;
        gnt_c      = cpu_req_i | host_req_i;
        gnt_port_c = PORT_CPU;
        if (contend_c) begin
            gnt_port_c = (r_last == PORT_HOST) ? PORT_CPU : PORT_HOST;
        end else if (host_req_i) begin
            gnt_port_c = PORT_HOST;
        end
    end

    // Pointer only moves when a contended arbitration is actually taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= PORT_HOST;
        end else if (take_i && contend_c) begin
            r_last <= gnt_port_c;
        end
    end

endmodule

// File: rtl/ram_5x32_arbiter.sv
// Serialises CPU and SPI-host single-word accesses onto the shared ram_5x32 port.
module ram_5x32_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    input  logic              host_lock_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  contention_cnt_o
);

    state_e              r_state;
    state_e              w_state_nxt;
    port_e               r_port;
    logic                r_we;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_data;
    logic                r_cpu_ack;
    logic                r_host_ack;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_host_rdata;
    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_cpu_elig;
    logic                w_in_idle;
    logic                w_gnt;
    port_e               w_gnt_port;
    logic                w_contend;
    logic                w_grant;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_ram_we_d;
    logic                w_cpu_ack_d;
    logic                w_host_ack_d;
    logic                w_cpu_cap;
    logic                w_host_cap;

    assign w_cpu_elig = cpu_req_i & ~host_lock_i;
    assign w_in_idle  = (r_state == IDLE);

    rr_arbiter_2 u_rr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cpu_req_i  (w_cpu_elig),
        .host_req_i (host_req_i),
        .take_i     (w_in_idle),
        .gnt_c      (w_gnt),
        .gnt_port_c (w_gnt_port),
        .contend_c  (w_contend)
    );

    // Next state and next values of the registered outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_ram_we_d   = 1'b0;
        w_cpu_ack_d  = 1'b0;
        w_host_ack_d = 1'b0;
        w_cpu_cap    = 1'b0;
        w_host_cap   = 1'b0;
        w_sel_we     = (w_gnt_port == PORT_HOST) ? host_we_i    : cpu_we_i;
        w_sel_addr   = (w_gnt_port == PORT_HOST) ? host_addr_i  : cpu_addr_i;
        w_sel_wdata  = (w_gnt_port == PORT_HOST) ? host_wdata_i : cpu_wdata_i;
        case (r_state)
            IDLE: begin
                if (w_gnt) begin
                    w_grant     = 1'b1;
                    w_ram_we_d  = w_sel_we;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_cpu_ack_d  = (r_port == PORT_CPU);
                w_host_ack_d = (r_port == PORT_HOST);
                w_state_nxt  = RESP;
            end
            RESP: begin
                w_cpu_cap   = (r_port == PORT_CPU)  && !r_we;
                w_host_cap  = (r_port == PORT_HOST) && !r_we;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant capture, RAM drive, acks, read-data capture and contention count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_port       <= PORT_CPU;
            r_we         <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_busy       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_ram_we   <= w_ram_we_d;
            r_cpu_ack  <= w_cpu_ack_d;
            r_host_ack <= w_host_ack_d;
            r_busy     <= (w_state_nxt != IDLE);
            if (w_grant) begin
                r_port     <= w_gnt_port;
                r_we       <= w_sel_we;
                r_ram_addr <= w_sel_addr;
                r_ram_data <= w_sel_wdata;
                if (w_contend && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_cpu_cap) begin
                r_cpu_rdata <= ram_data_i;
            end
            if (w_host_cap) begin
                r_host_rdata <= ram_data_i;
            end
        end
    end

    assign cpu_ack_o        = r_cpu_ack;
    assign cpu_rdata_o      = r_cpu_rdata;
    assign host_ack_o       = r_host_ack;
    assign host_rdata_o     = r_host_rdata;
    assign ram_we_o         = r_ram_we;
    assign ram_addr_o       = r_ram_addr;
    assign ram_data_o       = r_ram_data;
    assign busy_o           = r_busy;
    assign contention_cnt_o = r_cnt;

endmodule

// File: tb/tb_ram_5x32_arbiter.sv
// Directed bench for ram_5x32_arbiter with a behavioural one-cycle-latency ram_5x32 model.
module tb_ram_5x32_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned SAT_CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_ack, host_ack, ram_we, busy;
    logic [DW-1:0] cpu_rdata, host_rdata, ram_wdata, ram_q;
    logic [AW-1:0] ram_addr;
    logic [CW-1:0] cnt;

    // Separate narrow-counter instance, both ports permanently contending when enabled.
    logic              sat_req;
    logic [AW-1:0]     sat_addr;
    logic [DW-1:0]     sat_zero;
    logic              sat_cpu_ack, sat_host_ack, sat_ram_we, sat_busy;
    logic [DW-1:0]     sat_cpu_rdata, sat_host_rdata, sat_ram_data;
    logic [AW-1:0]     sat_ram_addr;
    logic [SAT_CW-1:0] sat_cnt;

    logic          preload;
    logic [DW-1:0] mem [32];

    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 31) ? 32'h1234_5678 : 32'h0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    ram_5x32_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_ack_o(host_ack), .host_rdata_o(host_rdata),
        .host_lock_i(host_lock),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_q),
        .busy_o(busy), .contention_cnt_o(cnt)
    );

    ram_5x32_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(SAT_CW)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(sat_req), .cpu_we_i(1'b0), .cpu_addr_i(sat_addr), .cpu_wdata_i(sat_zero),
        .cpu_ack_o(sat_cpu_ack), .cpu_rdata_o(sat_cpu_rdata),
        .host_req_i(sat_req), .host_we_i(1'b0), .host_addr_i(sat_addr), .host_wdata_i(sat_zero),
        .host_ack_o(sat_host_ack), .host_rdata_o(sat_host_rdata),
        .host_lock_i(1'b0),
        .ram_we_o(sat_ram_we), .ram_addr_o(sat_ram_addr), .ram_data_o(sat_ram_data), .ram_data_i(sat_zero),
        .busy_o(sat_busy), .contention_cnt_o(sat_cnt)
    );

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_cpu_rd = '0;
    logic [DW-1:0] exp_host_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          is_host;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    // One solo access: ack two cycles after the sampling edge, one-cycle write strobe.
    task automatic run_txn(input vec_t v);
        int lat;
        logic ack, other_ack;
        lat = 0;
        other_ack = 1'b0;
        @(negedge clk);
        cpu_we = v.we;  cpu_addr = v.addr;  cpu_wdata = v.wdata;
        host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
        cpu_req = !v.is_host;
        host_req = v.is_host;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("txn_we_access", 32'(ram_we), 32'(v.we));
                check("txn_ram_addr", 32'(ram_addr), 32'(v.addr));
                if (v.we) check("txn_ram_wdata", ram_wdata, v.wdata);
            end
            ack       = v.is_host ? host_ack : cpu_ack;
            other_ack = v.is_host ? cpu_ack : host_ack;
            if (ack) lat = c;
        end
        check("txn_ack_latency", 32'(lat), 32'd2);
        check("txn_we_one_cycle", 32'(ram_we), 32'd0);
        check("txn_other_ack", 32'(other_ack), 32'd0);
        cpu_req = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        if (!v.we) begin
            if (v.is_host) exp_host_rd = v.exp_rdata;
            else           exp_cpu_rd  = v.exp_rdata;
        end
        check("txn_cpu_rdata", cpu_rdata, exp_cpu_rd);
        check("txn_host_rdata", host_rdata, exp_host_rd);
    endtask

    initial begin
        port_e order [6];
        int    ack_cyc [6];
        int    k, host_seen, cpu_locked, lat, bad, sat_acks;

        vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 5'd31, 32'h0,         32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  32'hA5A5_A5A5, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b1, 5'd31, 32'h0000_0001, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 5'd31, 32'h0,         32'h0000_0001};
        vecs[8] = '{1'b1, 1'b0, 5'd7,  32'h0,         32'h0};

        rst_n = 1'b0; preload = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        host_lock = 0; sat_req = 0; sat_addr = '0; sat_zero = '0;
        repeat (3) @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_acks", 32'({cpu_ack, host_ack}), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        preload = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Continuous contention: strict alternation starting with the CPU.
        @(negedge clk);
        cpu_we = 0; host_we = 0; cpu_addr = 5'd5; host_addr = 5'd31;
        cpu_req = 1; host_req = 1;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clk);
            if (cpu_ack && host_ack) check("cont_dual_ack", 32'd1, 32'd0);
            if (cpu_ack || host_ack) begin
                order[k] = host_ack ? PORT_HOST : PORT_CPU;
                ack_cyc[k] = c;
                k++;
            end
        end
        cpu_req = 0; host_req = 0;
        check("cont_grants", 32'(k), 32'd6);
        for (int i = 0; i < k; i++) begin
            check("cont_order", 32'(order[i]), (i % 2 == 1) ? 32'(PORT_HOST) : 32'(PORT_CPU));
            if (i > 0) check("cont_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end
        repeat (2) @(negedge clk);
        check("cont_cnt", 32'(cnt), 32'd6);
        check("cont_idle", 32'(busy), 32'd0);

        // Lock: host alone is served; CPU wins the contention right after release.
        host_lock = 1; cpu_req = 1; host_req = 1;
        host_seen = 0; cpu_locked = 0;
        for (int c = 0; c < 30 && host_seen < 3; c++) begin
            @(negedge clk);
            if (cpu_ack) cpu_locked++;
            if (host_ack) host_seen++;
        end
        check("lock_host_acks", 32'(host_seen), 32'd3);
        check("lock_cpu_blocked", 32'(cpu_locked), 32'd0);
        host_lock = 0;
        lat = 0; bad = 0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (host_ack) bad++;
            if (cpu_ack) lat = c;
        end
        cpu_req = 0; host_req = 0;
        check("unlock_cpu_latency", 32'(lat), 32'd3);
        check("unlock_no_host_first", 32'(bad), 32'd0);
        check("unlock_cnt", 32'(cnt), 32'd7);
        repeat (2) @(negedge clk);

        // Lock raised during a CPU access: that access still completes, nothing after.
        cpu_we = 0; cpu_addr = 5'd3; cpu_req = 1;
        @(negedge clk);
        check("lockmid_access", 32'(busy), 32'd1);
        host_lock = 1;
        @(negedge clk);
        check("lockmid_ack", 32'(cpu_ack), 32'd1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || busy) bad++;
        end
        check("lockmid_no_regrant", 32'(bad), 32'd0);
        cpu_req = 0; host_lock = 0;
        @(negedge clk);

        // Reset during the ACCESS cycle of a write.
        cpu_we = 1; cpu_addr = 5'd7; cpu_wdata = 32'h0BAD_F00D; cpu_req = 1;
        @(negedge clk);
        check("rstmid_we_before", 32'(ram_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_we_drop", 32'(ram_we), 32'd0);
        check("rstmid_cnt", 32'(cnt), 32'd0);
        cpu_req = 0;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (cpu_ack || host_ack) bad++;
        end
        rst_n = 1'b1;
        #1;
        check("rstrel_busy", 32'(busy), 32'd0);
        check("rstrel_cnt", 32'(cnt), 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || host_ack) bad++;
        end
        check("rstmid_no_ack", 32'(bad), 32'd0);
        exp_cpu_rd = '0; exp_host_rd = '0;
        check("rstrel_cpu_rdata", cpu_rdata, 32'd0);
        run_txn(vecs[8]);

        // Saturation on the narrow-counter instance: 20 contended grants into a 4-bit counter.
        @(negedge clk);
        sat_req = 1;
        sat_acks = 0;
        for (int c = 0; c < 120 && sat_acks < 20; c++) begin
            @(negedge clk);
            if (sat_cpu_ack || sat_host_ack) begin
                sat_acks++;
                if (sat_acks == 10) check("sat_cnt_mid", 32'(sat_cnt), 32'd10);
            end
        end
        sat_req = 0;
        check("sat_acks", 32'(sat_acks), 32'd20);
        check("sat_cnt_full", 32'(sat_cnt), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
